// File: rtl/overlap_pkg.sv
// -----------------------------------------------------------------------------
// overlap_pkg
// Shared definitions for the overlap_ratio block:
//   state_t        sequencing states of the ratio unit
//   DEFAULT_CNT_W  default width of every region pixel count
//   HIT_AB/HIT_BC/HIT_ABC  bit positions inside the o_hit vector
// -----------------------------------------------------------------------------
package overlap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_AB  = 2'd1,
    DIV_BC  = 2'd2,
    DIV_ABC = 2'd3
  } state_t;

  localparam int DEFAULT_CNT_W = 13;

  localparam int HIT_AB  = 0;
  localparam int HIT_BC  = 1;
  localparam int HIT_ABC = 2;

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Serial restoring divider producing one quotient bit per clock, MSB first.
// The first step (integer bit) is taken combinationally from num/den in the
// cycle load is high; the remaining STEPS-1 fractional steps follow on the
// registered remainder. Degenerate operands are detected at load and override
// the arithmetic result, but the division still occupies all STEPS cycles.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   load      start a division this cycle (performs step 0)
//   num       numerator, unsigned CNT_W bits
//   den       divisor, signed CNT_W+2 bits (two's complement)
//   quotient  unsigned Q1.(STEPS-1) result, valid while done is high
//   done      high during the final step cycle
//   running   high during steps 1..STEPS-1
// -----------------------------------------------------------------------------
module seq_divider
  import overlap_pkg::*;
#(
  parameter int STEPS = 9,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [CNT_W-1:0]   num,
  input  logic [CNT_W+1:0]   den,
  output logic [STEPS-1:0]   quotient,
  output logic               done,
  output logic               running
);

  localparam int R_W = CNT_W + 2;
  localparam int C_W = (STEPS > 2) ? $clog2(STEPS) : 1;
  localparam logic [STEPS-1:0] SAT_VAL = STEPS'(1) << (STEPS - 1);

  logic [R_W-1:0]   rem;
  logic [R_W-1:0]   den_q;
  logic [STEPS-1:0] quo;
  logic [C_W-1:0]   cnt;
  logic             zero_q;
  logic             sat_q;

  logic [R_W-1:0]   r_in;
  logic [R_W-1:0]   d_in;
  logic [R_W-1:0]   r_out;
  logic             q_bit;
  logic             zero_now;
  logic             sat_now;

  // One restoring step. On load the numerator itself is the partial
  // remainder (integer bit); afterwards the stored remainder is doubled.
  // The remainder stays below the divisor on the normal path, so doubling
  // it always fits in CNT_W+2 bits.
  always_comb begin
    r_in     = load ? R_W'(num) : (rem << 1);
    d_in     = load ? den : den_q;
    q_bit    = (r_in >= d_in);
    r_out    = q_bit ? (r_in - d_in) : r_in;
    zero_now = ($signed(den) <= $signed(R_W'(0)));
    sat_now  = !zero_now && (R_W'(num) > den);
  end

  assign done = running && (cnt == C_W'(STEPS - 1));

  // Degenerate cases win over whatever the arithmetic produced.
  always_comb begin
    quotient = (quo << 1) | STEPS'(q_bit);
    if (zero_q) begin
      quotient = '0;
    end else if (sat_q) begin
      quotient = SAT_VAL;
    end
  end

  // Step counter, remainder and partial quotient registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      den_q   <= '0;
      quo     <= '0;
      cnt     <= '0;
      zero_q  <= 1'b0;
      sat_q   <= 1'b0;
      running <= 1'b0;
    end else if (load) begin
      rem     <= r_out;
      den_q   <= den;
      quo     <= STEPS'(q_bit);
      cnt     <= C_W'(1);
      zero_q  <= zero_now;
      sat_q   <= sat_now;
      running <= 1'b1;
    end else if (running) begin
      rem <= r_out;
      quo <= (quo << 1) | STEPS'(q_bit);
      if (done) begin
        cnt     <= '0;
        running <= 1'b0;
      end else begin
        cnt <= cnt + C_W'(1);
      end
    end
  end

endmodule

// File: rtl/overlap_ratio.sv
// -----------------------------------------------------------------------------
// overlap_ratio
// Computes three Q1.FRAC overlap ratios from six region counts using one
// shared serial divider, and flags each against THRESH:
//   o_iou_ab  = AB  / (A + B - AB)
//   o_iou_bc  = BC  / (B + C - BC)
//   o_persist = ABC / AB
// Latency from the accepting edge to o_valid is 3*(FRAC+1) cycles.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               one-cycle start pulse, accepted only when idle
//   i_A..i_ABC            region pixel counts, sampled at acceptance
//   o_iou_ab/o_iou_bc/o_persist  ratio results, held until next o_valid
//   o_hit                 [HIT_AB]/[HIT_BC]/[HIT_ABC] ratio >= THRESH
//   o_busy                high while a computation is in flight
//   o_valid               one-cycle pulse when results update
// -----------------------------------------------------------------------------
module overlap_ratio
  import overlap_pkg::*;
#(
  parameter int FRAC   = 8,
  parameter int THRESH = 128,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_A,
  input  logic [CNT_W-1:0] i_B,
  input  logic [CNT_W-1:0] i_C,
  input  logic [CNT_W-1:0] i_AB,
  input  logic [CNT_W-1:0] i_BC,
  input  logic [CNT_W-1:0] i_ABC,
  output logic [FRAC:0]    o_iou_ab,
  output logic [FRAC:0]    o_iou_bc,
  output logic [FRAC:0]    o_persist,
  output logic [2:0]       o_hit,
  output logic             o_busy,
  output logic             o_valid
);

  localparam int Q_W = FRAC + 1;
  localparam int R_W = CNT_W + 2;
  localparam logic [Q_W-1:0] THRESH_Q = Q_W'(THRESH);

  state_t state, state_next;

  logic [CNT_W-1:0] a, b, c, ab, bc, abc;
  logic [Q_W-1:0]   res_ab, res_bc;

  logic [CNT_W-1:0] div_num;
  logic [R_W-1:0]   div_den;
  logic             div_load;
  logic             div_done;
  logic             div_running;
  logic [Q_W-1:0]   div_quo;
  logic [2:0]       hit_next;

  // Operand selection: the union is formed in CNT_W+2 bits so that
  // inconsistent counts produce a negative (two's complement) divisor
  // instead of wrapping to a large positive one.
  always_comb begin
    div_num = '0;
    div_den = '0;
    case (state)
      DIV_AB: begin
        div_num = ab;
        div_den = R_W'(a) + R_W'(b) - R_W'(ab);
      end
      DIV_BC: begin
        div_num = bc;
        div_den = R_W'(b) + R_W'(c) - R_W'(bc);
      end
      DIV_ABC: begin
        div_num = abc;
        div_den = R_W'(ab);
      end
      default: begin
        div_num = '0;
        div_den = '0;
      end
    endcase
  end

  // A new division starts in the first cycle of each DIV state, which is
  // exactly when the divider is not already stepping.
  assign div_load = (state != IDLE) && !div_running;

  // Next-state logic: each DIV state lasts until its division completes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start)  state_next = DIV_AB;
      DIV_AB:  if (div_done) state_next = DIV_BC;
      DIV_BC:  if (div_done) state_next = DIV_ABC;
      DIV_ABC: if (div_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The persistence quotient comes straight from the divider, the other
  // two from the intermediate result registers.
  always_comb begin
    hit_next          = '0;
    hit_next[HIT_AB]  = (res_ab >= THRESH_Q);
    hit_next[HIT_BC]  = (res_bc >= THRESH_Q);
    hit_next[HIT_ABC] = (div_quo >= THRESH_Q);
  end

  // Operand capture, intermediate results and the visible outputs. All
  // three ratios are published together with o_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a         <= '0;
      b         <= '0;
      c         <= '0;
      ab        <= '0;
      bc        <= '0;
      abc       <= '0;
      res_ab    <= '0;
      res_bc    <= '0;
      o_iou_ab  <= '0;
      o_iou_bc  <= '0;
      o_persist <= '0;
      o_hit     <= '0;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            a      <= i_A;
            b      <= i_B;
            c      <= i_C;
            ab     <= i_AB;
            bc     <= i_BC;
            abc    <= i_ABC;
            o_busy <= 1'b1;
          end
        end
        DIV_AB: begin
          if (div_done) res_ab <= div_quo;
        end
        DIV_BC: begin
          if (div_done) res_bc <= div_quo;
        end
        DIV_ABC: begin
          if (div_done) begin
            o_iou_ab  <= res_ab;
            o_iou_bc  <= res_bc;
            o_persist <= div_quo;
            o_hit     <= hit_next;
            o_busy    <= 1'b0;
            o_valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  seq_divider #(
    .STEPS (Q_W),
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (div_load),
    .num      (div_num),
    .den      (div_den),
    .quotient (div_quo),
    .done     (div_done),
    .running  (div_running)
  );

endmodule

// File: tb/tb_overlap_ratio.sv
// -----------------------------------------------------------------------------
// tb_overlap_ratio
// Self-checking bench for overlap_ratio. Expected ratios come from a plain
// integer model of the overlap formulas (floor of N*2^FRAC/D with the
// empty-union and saturation rules), compared with immediate assertions.
// -----------------------------------------------------------------------------
module tb_overlap_ratio;

  localparam int FRAC   = 8;
  localparam int THRESH = 128;
  localparam int CNT_W  = 13;
  localparam int LAT    = 3 * (FRAC + 1);
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] in_a, in_b, in_c, in_ab, in_bc, in_abc;
  logic [FRAC:0]    iou_ab, iou_bc, persist;
  logic [2:0]       hit;
  logic             busy, valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  overlap_ratio #(
    .FRAC   (FRAC),
    .THRESH (THRESH),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_A       (in_a),
    .i_B       (in_b),
    .i_C       (in_c),
    .i_AB      (in_ab),
    .i_BC      (in_bc),
    .i_ABC     (in_abc),
    .o_iou_ab  (iou_ab),
    .o_iou_bc  (iou_bc),
    .o_persist (persist),
    .o_hit     (hit),
    .o_busy    (busy),
    .o_valid   (valid)
  );

  // Reference ratio: intersection over a signed union, floored.
  function automatic int refRatio(input int n, input int d);
    if (d <= 0) return 0;
    if (n >= d) return 1 << FRAC;
    return (n << FRAC) / d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive operands at a falling edge and pulse start across one rising edge.
  task automatic applyStimulus(input int a, input int b, input int c,
                               input int ab, input int bc, input int abc);
    in_a   = CNT_W'(a);
    in_b   = CNT_W'(b);
    in_c   = CNT_W'(c);
    in_ab  = CNT_W'(ab);
    in_bc  = CNT_W'(bc);
    in_abc = CNT_W'(abc);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Wait (bounded) for o_valid after acceptance, counting busy cycles.
  // With inject set, extra start pulses and input changes are applied
  // while the computation is in flight.
  task automatic waitValid(input bit inject, output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = busy ? 1 : 0;
    while (cycles < 60) begin
      start = inject && (cycles == 5 || cycles == 20);
      if (start) begin
        in_a  = CNT_W'($urandom_range(0, MAXC));
        in_ab = CNT_W'($urandom_range(0, MAXC));
        in_bc = CNT_W'($urandom_range(0, MAXC));
      end
      @(negedge clk);
      cycles++;
      if (valid) break;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
  endtask

  task automatic checkResult(input string tag, input int a, input int b, input int c,
                             input int ab, input int bc, input int abc);
    int eab, ebc, ep, eh;
    eab = refRatio(ab, a + b - ab);
    ebc = refRatio(bc, b + c - bc);
    ep  = refRatio(abc, ab);
    eh  = ((ep >= THRESH) ? 4 : 0) + ((ebc >= THRESH) ? 2 : 0) + ((eab >= THRESH) ? 1 : 0);
    checkOutput({tag, "_iou_ab"}, 32'(iou_ab), eab);
    checkOutput({tag, "_iou_bc"}, 32'(iou_bc), ebc);
    checkOutput({tag, "_persist"}, 32'(persist), ep);
    checkOutput({tag, "_hit"}, 32'(hit), eh);
  endtask

  task automatic runCase(input string tag, input int a, input int b, input int c,
                         input int ab, input int bc, input int abc);
    int cycles, busy_cnt;
    applyStimulus(a, b, c, ab, bc, abc);
    waitValid(1'b0, cycles, busy_cnt);
    checkOutput({tag, "_latency"}, cycles, LAT);
    checkOutput({tag, "_busy_cycles"}, busy_cnt, LAT);
    checkOutput({tag, "_busy_at_valid"}, 32'(busy), 0);
    checkResult(tag, a, b, c, ab, bc, abc);
  endtask

  task automatic countValids(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (valid) cnt++;
    end
  endtask

  initial begin
    int cycles, busy_cnt, vcnt;
    int ra, rb, rc, rab, rbc, rabc, lim;

    rst_n  = 1'b0;
    start  = 1'b0;
    in_a   = '0;
    in_b   = '0;
    in_c   = '0;
    in_ab  = '0;
    in_bc  = '0;
    in_abc = '0;
    #22;
    checkOutput("reset_iou_ab", 32'(iou_ab), 0);
    checkOutput("reset_iou_bc", 32'(iou_bc), 0);
    checkOutput("reset_persist", 32'(persist), 0);
    checkOutput("reset_hit", 32'(hit), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_valid", 32'(valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed cases");
    runCase("basic", 100, 100, 100, 50, 100, 25);
    runCase("zeros", 0, 0, 0, 0, 0, 0);
    runCase("sat_ab", 30, 20, 10, 40, 0, 0);
    runCase("neg_union", 20, 30, 10, 60, 5, 0);
    runCase("max_equal", MAXC, MAXC, MAXC, MAXC, MAXC, MAXC);
    runCase("max_union", MAXC, MAXC, MAXC, 1, 1, 1);

    $display("[TB] random cases");
    for (int k = 0; k < 16; k++) begin
      lim  = (k % 2 == 0) ? MAXC : 40;
      ra   = $urandom_range(0, lim);
      rb   = $urandom_range(0, lim);
      rc   = $urandom_range(0, lim);
      rab  = $urandom_range(0, lim);
      rbc  = $urandom_range(0, lim);
      rabc = $urandom_range(0, lim);
      runCase($sformatf("rand%0d", k), ra, rb, rc, rab, rbc, rabc);
    end

    $display("[TB] ignored starts and back-to-back");
    applyStimulus(200, 150, 50, 100, 40, 60);
    waitValid(1'b1, cycles, busy_cnt);
    checkOutput("ignore_latency", cycles, LAT);
    checkResult("ignore", 200, 150, 50, 100, 40, 60);
    // Still in the o_valid cycle: this start must be accepted.
    applyStimulus(100, 100, 100, 50, 100, 25);
    waitValid(1'b0, cycles, busy_cnt);
    checkOutput("b2b_latency", cycles, LAT);
    checkOutput("b2b_busy_cycles", busy_cnt, LAT);
    checkResult("b2b", 100, 100, 100, 50, 100, 25);
    countValids(40, vcnt);
    checkOutput("b2b_no_extra_valid", vcnt, 0);
    checkResult("b2b_hold", 100, 100, 100, 50, 100, 25);

    $display("[TB] reset mid-operation");
    applyStimulus(300, 200, 100, 150, 60, 90);
    for (int i = 0; i < 12; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_iou_ab", 32'(iou_ab), 0);
    checkOutput("midrst_iou_bc", 32'(iou_bc), 0);
    checkOutput("midrst_persist", 32'(persist), 0);
    checkOutput("midrst_hit", 32'(hit), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    countValids(40, vcnt);
    checkOutput("midrst_no_valid", vcnt, 0);
    checkOutput("midrst_busy_after", 32'(busy), 0);
    runCase("after_rst", 100, 100, 100, 50, 100, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
